rggen_external_window_bridge: RTL

- Multi-window successor to the single-window external register bridge.
- Decodes one register-bus access against WINDOWS address windows and forwards it to the matching external bus channel with a window-relative offset.
- Waits for that channel's done and returns a registered, one-cycle response.
- Sits between the register block's access fabric and external sub-blocks. Adds per-channel routing, decode priority, response capture and an optional timeout.

---
 rtl/rggen_external_window_bridge.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rggen_external_window_bridge.sv
// ============================================================================
// rggen_external_window_bridge : multi-window external register bus bridge
// Optional BUSY timeout enabled by RGGEN_EXTERNAL_TIMEOUT_EN. Revision 1.0
// ============================================================================
`default_nettype none

module rggen_external_window_bridge #(
  parameter int                                ADDRESS_WIDTH     = 16,
  parameter int                                DATA_WIDTH        = 32,
  parameter int                                WINDOWS           = 2,
  parameter logic [WINDOWS*ADDRESS_WIDTH-1:0]  START_ADDRESS     = '0,
  parameter logic [WINDOWS*ADDRESS_WIDTH-1:0]  END_ADDRESS       = '0,
  parameter int                                EXT_ADDRESS_WIDTH = 16,
  parameter int                                TIMEOUT_CYCLES    = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_request,
  input  logic [ADDRESS_WIDTH-1:0]        i_address,
  input  logic                            i_direction,
  input  logic [DATA_WIDTH-1:0]           i_write_data,
  input  logic [DATA_WIDTH/8-1:0]         i_write_strobe,
  output logic                            o_select,
  output logic                            o_ready,
  output logic [DATA_WIDTH-1:0]           o_read_data,
  output logic [1:0]                      o_status,
  output logic [WINDOWS-1:0]              o_ext_request,
  output logic [EXT_ADDRESS_WIDTH-1:0]    o_ext_address,
  output logic                            o_ext_direction,
  output logic [DATA_WIDTH-1:0]           o_ext_write_data,
  output logic [DATA_WIDTH/8-1:0]         o_ext_write_strobe,
  input  logic [WINDOWS-1:0]              i_ext_done,
  input  logic [WINDOWS*DATA_WIDTH-1:0]   i_ext_read_data,
  input  logic [WINDOWS*2-1:0]            i_ext_status
);

  localparam int c_IDX_WIDTH = (WINDOWS > 1) ? $clog2(WINDOWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESPOND = 2'd2
  } state_e;

  state_e                         state_q;
  logic [c_IDX_WIDTH-1:0]         index_q;
  logic [WINDOWS-1:0]             ext_request_q;
  logic [EXT_ADDRESS_WIDTH-1:0]   ext_address_q;
  logic                           ext_direction_q;
  logic [DATA_WIDTH-1:0]          ext_write_data_q;
  logic [DATA_WIDTH/8-1:0]        ext_write_strobe_q;
  logic                           ready_q;
  logic [DATA_WIDTH-1:0]          read_data_q;
  logic [1:0]                     status_q;

  logic [WINDOWS-1:0]             w_hit;
  logic [ADDRESS_WIDTH-1:0]       w_offset   [WINDOWS];
  logic [DATA_WIDTH-1:0]          w_ch_rdata [WINDOWS];
  logic [1:0]                     w_ch_status[WINDOWS];
  logic [c_IDX_WIDTH-1:0]         w_index;
  logic [WINDOWS-1:0]             w_onehot;
  logic                           w_done;
  logic                           w_timeout;

  // Borrow-based compares keep the window decode free of constant-range compares.
  for (genvar g = 0; g < WINDOWS; g++) begin : g_window
    logic [ADDRESS_WIDTH:0] w_above;
    logic [ADDRESS_WIDTH:0] w_below;
    assign w_above = {1'b0, i_address} - {1'b0, START_ADDRESS[g*ADDRESS_WIDTH +: ADDRESS_WIDTH]};
    assign w_below = {1'b0, END_ADDRESS[g*ADDRESS_WIDTH +: ADDRESS_WIDTH]} - {1'b0, i_address};
    assign w_hit[g]       = ~w_above[ADDRESS_WIDTH] & ~w_below[ADDRESS_WIDTH];
    assign w_offset[g]    = w_above[ADDRESS_WIDTH-1:0];
    assign w_ch_rdata[g]  = i_ext_read_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_ch_status[g] = i_ext_status[g*2 +: 2];
  end

  always_comb begin
    w_index  = '0;
    w_onehot = '0;
    for (int i = WINDOWS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_index = c_IDX_WIDTH'(i);
      end
    end
    for (int i = 0; i < WINDOWS; i++) begin
      w_onehot[i] = (w_index == c_IDX_WIDTH'(i));
    end
  end

  assign o_select = |w_hit;
  assign w_done   = i_ext_done[index_q];

`ifdef RGGEN_EXTERNAL_TIMEOUT_EN
  localparam int                   c_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_WIDTH-1:0] c_LIMIT   = c_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_WIDTH-1:0] count_q;

  // count_q holds the number of BUSY cycles already completed before this one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (state_q != S_BUSY) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign w_timeout = ~w_done & (count_q == c_LIMIT);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      index_q            <= '0;
      ext_request_q      <= '0;
      ext_address_q      <= '0;
      ext_direction_q    <= 1'b0;
      ext_write_data_q   <= '0;
      ext_write_strobe_q <= '0;
      ready_q            <= 1'b0;
      read_data_q        <= '0;
      status_q           <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_request && o_select) begin
            state_q            <= S_BUSY;
            index_q            <= w_index;
            ext_request_q      <= w_onehot;
            ext_address_q      <= EXT_ADDRESS_WIDTH'(w_offset[w_index]);
            ext_direction_q    <= i_direction;
            ext_write_data_q   <= i_write_data;
            ext_write_strobe_q <= i_write_strobe;
          end
        end
        S_BUSY: begin
          if (w_done || w_timeout) begin
            state_q            <= S_RESPOND;
            ready_q            <= 1'b1;
            read_data_q        <= (w_timeout || ext_direction_q) ? '0 : w_ch_rdata[index_q];
            status_q           <= w_timeout ? 2'd2 : w_ch_status[index_q];
            ext_request_q      <= '0;
            ext_address_q      <= '0;
            ext_direction_q    <= 1'b0;
            ext_write_data_q   <= '0;
            ext_write_strobe_q <= '0;
          end
        end
        S_RESPOND: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b0;
          read_data_q <= '0;
          status_q    <= 2'd0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready            = ready_q;
  assign o_read_data        = read_data_q;
  assign o_status           = status_q;
  assign o_ext_request      = ext_request_q;
  assign o_ext_address      = ext_address_q;
  assign o_ext_direction    = ext_direction_q;
  assign o_ext_write_data   = ext_write_data_q;
  assign o_ext_write_strobe = ext_write_strobe_q;

endmodule

`default_nettype wire
